multi_space_parking_controller: RTL and testbench

Parametrised successor to the single-gate parking controller. It adds configurable code width, a configurable attempt limit, a PIN-entry timeout, a timed gate-closing phase and an admin unblock code. It also tracks lot occupancy up to a capacity and refuses entry when the lot is full. It sits between the entry-gate sensors and keypad on one side and the gate actuator and status panel on the other.

---
 rtl/multi_space_parking_controller.sv | 164 ++++++++++++++++
 tb/tb_multi_space_parking_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multi_space_parking_controller.sv
// Entry-gate controller: keypad PIN check with attempt limit and timeout,
// timed gate close, admin unblock, and lot occupancy tracking up to CAPACITY.
module multi_space_parking_controller #(
  parameter int unsigned       CODE_W       = 16,
  parameter logic [CODE_W-1:0] CORRECT_CODE = 16'h2468,
  parameter logic [CODE_W-1:0] ADMIN_CODE   = 16'hA5A5,
  parameter int unsigned       MAX_ATTEMPTS = 3,
  parameter int unsigned       CAPACITY     = 8,
  parameter int unsigned       PIN_TIMEOUT  = 64,
  parameter int unsigned       CLOSE_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_vehicle_arrival,
  input  logic                                i_vehicle_left,
  input  logic                                i_vehicle_exit,
  input  logic [CODE_W-1:0]                   i_code,
  input  logic                                i_code_ack,
  output logic                                o_open_gate,
  output logic                                o_close_gate,
  output logic                                o_wrong_pin,
  output logic                                o_blocked_gate,
  output logic                                o_lot_full,
  output logic [$clog2(CAPACITY+1)-1:0]       o_occupancy,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   o_attempts
);

  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
  localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned TMO_W = $clog2(PIN_TIMEOUT + 1);
  localparam int unsigned CLS_W = $clog2(CLOSE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_PIN, GATE_OPEN, CLOSING, BLOCKED
  } state_t;

  state_t             r_state;
  logic               r_open_gate;
  logic               r_close_gate;
  logic               r_wrong_pin;
  logic               r_blocked_gate;
  logic               r_lot_full;
  logic [OCC_W-1:0]   r_occ;
  logic [ATT_W-1:0]   r_attempts;
  logic [TMO_W-1:0]   r_tmo;
  logic [CLS_W-1:0]   r_cls;

  logic               w_occ_inc;
  logic [OCC_W-1:0]   w_occ_nxt;
  logic [ATT_W-1:0]   w_att_inc;

  assign w_occ_inc = (r_state == GATE_OPEN) && i_vehicle_left;
  assign w_att_inc = r_attempts + ATT_W'(1);

  // Saturating occupancy; a simultaneous entry and exit cancel out.
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_occ_inc && !i_vehicle_exit) begin
      if (r_occ != OCC_W'(CAPACITY)) w_occ_nxt = r_occ + OCC_W'(1);
    end else if (!w_occ_inc && i_vehicle_exit) begin
      if (r_occ != '0) w_occ_nxt = r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_open_gate    <= 1'b0;
      r_close_gate   <= 1'b0;
      r_wrong_pin    <= 1'b0;
      r_blocked_gate <= 1'b0;
      r_lot_full     <= 1'b0;
      r_occ          <= '0;
      r_attempts     <= '0;
      r_tmo          <= '0;
      r_cls          <= '0;
    end else begin
      r_wrong_pin <= 1'b0;
      r_occ       <= w_occ_nxt;
      r_lot_full  <= (w_occ_nxt == OCC_W'(CAPACITY));

      case (r_state)
        IDLE: begin
          if (i_vehicle_arrival && !r_lot_full) begin
            r_state <= WAIT_PIN;
            r_tmo   <= '0;
          end
        end

        // code_ack outranks the timeout expiring on the same cycle
        WAIT_PIN: begin
          if (i_code_ack) begin
            if (i_code == CORRECT_CODE) begin
              r_state     <= GATE_OPEN;
              r_open_gate <= 1'b1;
              r_attempts  <= '0;
            end else begin
              r_wrong_pin <= 1'b1;
              r_attempts  <= w_att_inc;
              if (w_att_inc == ATT_W'(MAX_ATTEMPTS)) begin
                r_state        <= BLOCKED;
                r_blocked_gate <= 1'b1;
              end else begin
                r_tmo <= '0;
              end
            end
          end else if (r_tmo == TMO_W'(PIN_TIMEOUT - 1)) begin
            r_state    <= IDLE;
            r_attempts <= '0;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end

        GATE_OPEN: begin
          if (i_vehicle_left) begin
            r_open_gate <= 1'b0;
            if (i_vehicle_arrival) begin
              r_state        <= BLOCKED;
              r_blocked_gate <= 1'b1;
            end else begin
              r_state      <= CLOSING;
              r_close_gate <= 1'b1;
              r_cls        <= '0;
            end
          end
        end

        CLOSING: begin
          if (r_cls == CLS_W'(CLOSE_CYCLES - 1)) begin
            r_state      <= IDLE;
            r_close_gate <= 1'b0;
          end else begin
            r_cls <= r_cls + CLS_W'(1);
          end
        end

        BLOCKED: begin
          if (i_code_ack && (i_code == ADMIN_CODE)) begin
            r_state        <= IDLE;
            r_blocked_gate <= 1'b0;
            r_attempts     <= '0;
          end
        end

        default: begin
          r_state        <= IDLE;
          r_open_gate    <= 1'b0;
          r_close_gate   <= 1'b0;
          r_blocked_gate <= 1'b0;
        end
      endcase
    end
  end

  assign o_open_gate    = r_open_gate;
  assign o_close_gate   = r_close_gate;
  assign o_wrong_pin    = r_wrong_pin;
  assign o_blocked_gate = r_blocked_gate;
  assign o_lot_full     = r_lot_full;
  assign o_occupancy    = r_occ;
  assign o_attempts     = r_attempts;

endmodule

// File: tb/tb_multi_space_parking_controller.sv
// Directed bench for multi_space_parking_controller with hand-computed expectations.
module tb_multi_space_parking_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        vehicle_arrival, vehicle_left, vehicle_exit, code_ack;
  logic [15:0] code;
  logic        open_gate, close_gate, wrong_pin, blocked_gate, lot_full;
  logic [3:0]  occupancy;
  logic [1:0]  attempts;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [15:0] GOOD  = 16'h2468;
  localparam logic [15:0] ADMIN = 16'hA5A5;
  localparam logic [15:0] BAD   = 16'h1111;

  multi_space_parking_controller dut (
    .clk               (clk),
    .rst               (rst),
    .i_vehicle_arrival (vehicle_arrival),
    .i_vehicle_left    (vehicle_left),
    .i_vehicle_exit    (vehicle_exit),
    .i_code            (code),
    .i_code_ack        (code_ack),
    .o_open_gate       (open_gate),
    .o_close_gate      (close_gate),
    .o_wrong_pin       (wrong_pin),
    .o_blocked_gate    (blocked_gate),
    .o_lot_full        (lot_full),
    .o_occupancy       (occupancy),
    .o_attempts        (attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic present(input logic [15:0] c);
    code = c; code_ack = 1'b1; tick(); code_ack = 1'b0;
  endtask

  // Full admit cycle: arrival, correct PIN, vehicle passes, gate closes.
  task automatic admit(input logic exit_too);
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    present(GOOD);
    vehicle_left = 1'b1; vehicle_exit = exit_too; tick();
    vehicle_left = 1'b0; vehicle_exit = 1'b0;
    tick(4);
  endtask

  initial begin
    rst = 1'b1; vehicle_arrival = 0; vehicle_left = 0; vehicle_exit = 0;
    code_ack = 0; code = '0;
    tick(2);
    rst = 1'b0;
    tick();
    check("rst_open", open_gate, 0);
    check("rst_blocked", blocked_gate, 0);
    check("rst_occ", occupancy, 0);
    check("rst_att", attempts, 0);

    // Normal entry and timed close
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    present(GOOD);
    check("open_after_ack", open_gate, 1);
    vehicle_left = 1'b1; tick(); vehicle_left = 1'b0;
    check("close_c1", close_gate, 1);
    check("open_off", open_gate, 0);
    check("occ_1", occupancy, 1);
    tick(3);
    check("close_c4", close_gate, 1);
    tick();
    check("close_done", close_gate, 0);

    // Wrong codes to block, then admin unblock
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      present(BAD);
      check("wrong_pulse", wrong_pin, 1);
      check("att_count", attempts, k);
      tick();
      check("wrong_low", wrong_pin, 0);
    end
    check("blocked", blocked_gate, 1);
    present(GOOD);
    check("blk_ignore_good", open_gate, 0);
    check("blk_still", blocked_gate, 1);
    check("blk_no_wrong", wrong_pin, 0);
    present(ADMIN);
    check("unblocked", blocked_gate, 0);
    check("att_clr", attempts, 0);

    // Ack on the 64th WAIT_PIN cycle beats the timeout
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    tick(63);
    present(GOOD);
    check("ack_at_expiry", open_gate, 1);
    vehicle_left = 1'b1; tick(); vehicle_left = 1'b0;
    check("occ_2", occupancy, 2);
    tick(4);

    // Timeout after 64 idle cycles, later code ignored
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    present(BAD);
    check("att_before_tmo", attempts, 1);
    tick(64);
    check("tmo_att_clr", attempts, 0);
    present(GOOD);
    check("tmo_idle_open", open_gate, 0);
    check("tmo_idle_wrong", wrong_pin, 0);

    // Tailgating blocks; exit still tracked while blocked
    vehicle_arrival = 1'b1; tick();
    present(GOOD);
    check("tg_open", open_gate, 1);
    vehicle_left = 1'b1; tick(); vehicle_left = 1'b0; vehicle_arrival = 1'b0;
    check("tg_blocked", blocked_gate, 1);
    check("tg_open_off", open_gate, 0);
    check("tg_occ", occupancy, 3);
    vehicle_exit = 1'b1; tick(); vehicle_exit = 1'b0;
    check("blk_exit_occ", occupancy, 2);
    present(ADMIN);
    check("tg_unblock", blocked_gate, 0);

    // Fill the lot
    for (int k = 0; k < 6; k++) admit(1'b0);
    check("full_occ", occupancy, 8);
    check("full_flag", lot_full, 1);
    vehicle_arrival = 1'b1; tick(2); vehicle_arrival = 1'b0;
    present(GOOD);
    check("full_no_open", open_gate, 0);
    vehicle_exit = 1'b1; tick(); vehicle_exit = 1'b0;
    check("exit_occ7", occupancy, 7);
    check("exit_not_full", lot_full, 0);
    vehicle_exit = 1'b1; tick(7);
    check("drain_occ0", occupancy, 0);
    tick(); vehicle_exit = 1'b0;
    check("exit_sat0", occupancy, 0);
    admit(1'b1);
    check("inc_dec_same", occupancy, 0);

    // Async reset in the middle of CLOSING
    vehicle_arrival = 1'b1; tick(); vehicle_arrival = 1'b0;
    present(GOOD);
    vehicle_left = 1'b1; tick(); vehicle_left = 1'b0;
    check("pre_rst_close", close_gate, 1);
    check("pre_rst_occ", occupancy, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_close", close_gate, 0);
    check("arst_occ", occupancy, 0);
    check("arst_open", open_gate, 0);
    tick();
    rst = 1'b0;
    tick(2);
    check("post_rst_close", close_gate, 0);
    check("post_rst_blocked", blocked_gate, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
